mem_access_unit: RTL and testbench

Per-core memory access unit sitting directly upstream of the shared-RAM memory controller (arbiter). It accepts single load/store commands from a core's control unit and asserts that core's `rden`/`wren` request bit. It holds the request until the controller's `acq` grant has been seen for the configured RAM latency, then captures read data, releases the request, and reports completion. One instance per core; each instance drives one bit of the controller's `rden`/`wren` vectors and one address/data byte lane.

---
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: per-core load/store requester in front of the shared-RAM arbiter.
// Define MAU_TIMEOUT_EN to bound the wait for acq and report err on expiry.
module mem_access_unit #(
    parameter int RD_WAIT = 2
`ifdef MAU_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    output logic       rden,
    output logic       wren,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_din,
    input  logic       acq,
    input  logic [7:0] mem_q
);
    localparam int CW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic          done_q, done_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic [7:0]    rdata_q, rdata_d;
`ifdef MAU_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
`ifdef MAU_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    wr_d    = wr;
                    addr_d  = addr;
                    din_d   = wdata;
                    state_d = REQ;
`ifdef MAU_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            REQ: begin
                // A grant already high on entry is taken as valid.
                if (acq) begin
                    cnt_d   = CW'(RD_WAIT - 1);
                    state_d = ACCESS;
                end
`ifdef MAU_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!wr_q) rdata_d = mem_q;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE: begin
                // Hold off until the arbiter drops its grant.
                if (!acq) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

`ifdef MAU_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    logic req;
    assign req      = (state_q == REQ) || (state_q == ACCESS);
    assign rden     = req & ~wr_q;
    assign wren     = req & wr_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized load/store traffic against a cycle-timeline model.
// Also covers back-to-back, ignored starts, reset mid-access and REQ stall/timeout.
module tb_mem_access_unit;
    localparam int RDW = 2;
`ifdef MAU_TIMEOUT_EN
    localparam int TMO = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       wr = 1'b0;
    logic       acq = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] mem_q = '0;
    logic       busy, done, err, rden, wren;
    logic [7:0] rdata, mem_addr, mem_din;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] m_rdata = '0;

    mem_access_unit #(
        .RD_WAIT(RDW)
`ifdef MAU_TIMEOUT_EN
        ,
        .TIMEOUT(TMO)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start(start), .wr(wr),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .err(err), .rdata(rdata), .rden(rden), .wren(wren),
        .mem_addr(mem_addr), .mem_din(mem_din), .acq(acq),
        .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        step();
        check("idle_busy", 8'(busy), 8'h0);
        check("idle_done", 8'(done), 8'h0);
    endtask

    // Called at the negedge of cycle 0 with the unit idle; returns at the
    // negedge of the done cycle. g = grant cycle, 0 = never granted.
    task automatic run_txn(input logic w, input logic [7:0] a,
                           input logic [7:0] d, input int g,
                           input logic [7:0] qv, input bit noise);
        int         last, dn;
        logic       req_e;
        logic [7:0] pend;
`ifdef MAU_TIMEOUT_EN
        if (g == 0) begin
            last = TMO;
            dn   = TMO + 1;
        end else
`endif
        begin
            last = g + RDW;
            dn   = g + RDW + 3;
        end
        pend  = m_rdata;
        start = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        acq   = 1'b0;
        for (int c = 1; c <= dn; c++) begin
            step();
            start = 1'b0;
            if (noise && c < dn && $urandom_range(3) == 0) begin
                start = 1'b1;
                wr    = 1'($urandom);
                addr  = 8'($urandom);
                wdata = 8'($urandom);
            end
            if (g > 0 && !w && c == g + RDW + 1) m_rdata = pend;
            req_e = (c <= last);
            check("busy", 8'(busy), 8'(c < dn));
            check("done", 8'(done), 8'(c == dn));
            check("err", 8'(err), 8'(g == 0 && c == dn));
            check("rden", 8'(rden), 8'(req_e & ~w));
            check("wren", 8'(wren), 8'(req_e & w));
            check("mem_addr", mem_addr, a);
            check("mem_din", mem_din, d);
            check("rdata", rdata, m_rdata);
            acq   = (g > 0 && c >= g && c <= g + RDW + 1);
            mem_q = (c == g + RDW) ? qv : 8'($urandom);
            if (c == g + RDW) pend = mem_q;
        end
        start = 1'b0;
        acq   = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 8'(busy), 8'h0);
        check("rst_done", 8'(done), 8'h0);
        check("rst_err", 8'(err), 8'h0);
        check("rst_rden", 8'(rden), 8'h0);
        check("rst_wren", 8'(wren), 8'h0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_addr", mem_addr, 8'h00);
        check("rst_din", mem_din, 8'h00);
        rst = 1'b0;
        idle_cycle();

        run_txn(1'b0, 8'h3C, 8'h00, 1, 8'hA5, 1'b0);
        check("load_a5", rdata, 8'hA5);
        idle_cycle();
        run_txn(1'b1, 8'h10, 8'h5A, 11, 8'h77, 1'b0);
        check("store_keeps", rdata, 8'hA5);
        idle_cycle();
        run_txn(1'b0, 8'h20, 8'h00, 2, 8'h3E, 1'b0);
        run_txn(1'b0, 8'h11, 8'h00, 1, 8'hC4, 1'b0);
        run_txn(1'b0, 8'h44, 8'h00, 3, 8'h66, 1'b1);

        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(6, 1)), 8'($urandom),
                    1'($urandom));
            if ($urandom_range(1) == 0) idle_cycle();
        end
        idle_cycle();

`ifdef MAU_TIMEOUT_EN
        run_txn(1'b1, 8'h99, 8'h33, 0, 8'h00, 1'b0);
        idle_cycle();
        run_txn(1'b0, 8'h98, 8'h00, 0, 8'h00, 1'b1);
        idle_cycle();
`else
        start = 1'b1;
        wr    = 1'b0;
        addr  = 8'h55;
        acq   = 1'b0;
        for (int c = 0; c < 120; c++) begin
            step();
            start = 1'b0;
            check("stall_busy", 8'(busy), 8'h1);
        end
        check("stall_rden", 8'(rden), 8'h1);
        rst = 1'b1;
        #1;
        check("stall_rst_busy", 8'(busy), 8'h0);
        step();
        rst     = 1'b0;
        m_rdata = 8'h00;
        idle_cycle();
`endif

        run_txn(1'b0, 8'h01, 8'h00, 1, 8'hC3, 1'b0);
        idle_cycle();
        start = 1'b1;
        wr    = 1'b0;
        addr  = 8'h77;
        step();
        start = 1'b0;
        acq   = 1'b1;
        step();
        check("acc_rden", 8'(rden), 8'h1);
        rst = 1'b1;
        #1;
        check("mid_rden", 8'(rden), 8'h0);
        check("mid_wren", 8'(wren), 8'h0);
        check("mid_busy", 8'(busy), 8'h0);
        check("mid_rdata", rdata, 8'h00);
        check("mid_addr", mem_addr, 8'h00);
        step();
        check("mid_done", 8'(done), 8'h0);
        rst     = 1'b0;
        acq     = 1'b0;
        m_rdata = 8'h00;
        idle_cycle();
        run_txn(1'b0, 8'h02, 8'h00, 2, 8'h5D, 1'b0);
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
